btn_event_gen: RTL and testbench

Front-end button conditioner for the mode-select controller. It synchronises and debounces the two raw pushbuttons, `change` and `accept`. It emits clean single-cycle event pulses that the top-level state machine consumes to step the interpolation mode (lin/poly/spline) and advance states. It sits between the board pins and the top FSM, and is the producing end of the change/accept event interface.

---
 rtl/yoda_pkg.sv | 20 ++
 rtl/debounce_chan.sv | 53 +++++
 rtl/btn_event_gen.sv | 119 +++++++++++
 tb/tb_btn_event_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/yoda_pkg.sv
// Shared definitions for the mode-select front end: button channel indices,
// auto-repeat state encoding and default timing constants for a 50 MHz clock.
package yoda_pkg;

    localparam int unsigned BTN_CHANGE = 0;
    localparam int unsigned BTN_ACCEPT = 1;
    localparam int unsigned NUM_BTN    = 2;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms
    localparam int unsigned DEF_CNT_W           = 25;

    typedef enum logic [1:0] {
        RepIdle,
        RepDelay,
        RepRepeat
    } rep_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, debounce counter and a
// single-cycle pulse on each rising edge of the debounced level.
module debounce_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] CntLim = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLim) begin
            level_d = ~level_q;
            cnt_d   = '0;
            pulse_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_event_gen.sv
// Change/accept event generator: two debounced channels, accept-over-change
// priority and, when BTN_AUTO_REPEAT_EN is defined, auto-repeat on change.
module btn_event_gen
    import yoda_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_change_raw,
    input  logic btn_accept_raw,
    output logic change,
    output logic accept,
    output logic change_level,
    output logic accept_level
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pulse;

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_change (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (btn_change_raw),
        .level_o(level[BTN_CHANGE]),
        .pulse_o(pulse[BTN_CHANGE])
    );

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_accept (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (btn_accept_raw),
        .level_o(level[BTN_ACCEPT]),
        .pulse_o(pulse[BTN_ACCEPT])
    );

    assign change_level = level[BTN_CHANGE];
    assign accept_level = level[BTN_ACCEPT];
    assign accept       = pulse[BTN_ACCEPT];

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DelayLim  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodLim = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             rep_q, rep_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rep_d   = 1'b0;
        unique case (state_q)
            RepIdle: begin
                timer_d = '0;
                // The press pulse is seen one cycle after it fires; that cycle counts.
                if (pulse[BTN_CHANGE]) begin
                    state_d = RepDelay;
                    timer_d = CNT_W'(1);
                end
            end
            RepDelay: begin
                if (timer_q >= DelayLim) begin
                    rep_d   = 1'b1;
                    state_d = RepRepeat;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            RepRepeat: begin
                if (timer_q >= PeriodLim) begin
                    rep_d   = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: state_d = RepIdle;
        endcase
        if (!level[BTN_CHANGE]) begin
            state_d = RepIdle;
            timer_d = '0;
            rep_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RepIdle;
            timer_q <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
        end
    end

    // Gating with the level drops a repeat registered on the edge the level falls.
    assign change = (pulse[BTN_CHANGE] | (rep_q & level[BTN_CHANGE])) & ~pulse[BTN_ACCEPT];
`else
    // Repeat timing stays on the interface but has no hardware in this build.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_unused
    end

    assign change = pulse[BTN_CHANGE] & ~pulse[BTN_ACCEPT];
`endif

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; expectations follow BTN_AUTO_REPEAT_EN when it is defined.
module tb_btn_event_gen;

    logic clk;
    logic rst_n;
    logic btn_change_raw;
    logic btn_accept_raw;
    logic change;
    logic accept;
    logic change_level;
    logic accept_level;

    int n_cmp;
    int n_err;

    btn_event_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_change_raw(btn_change_raw),
        .btn_accept_raw(btn_accept_raw),
        .change        (change),
        .accept        (accept),
        .change_level  (change_level),
        .accept_level  (accept_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_change_raw = 1'b0;
        btn_accept_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Cycle n is checked just before edge n, then the inputs for edge n are driven.
    task automatic run_scn(input string tag, input int ncyc,
                           input int c_on, input int c_off, input int a_on, input int a_off,
                           input int r_lo, input int r_hi,
                           input logic [127:0] exp_chg, input logic [127:0] exp_acc,
                           input int cl_on, input int cl_off, input int al_on, input int al_off);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            check_eq($sformatf("%s c%0d change", tag, n), change, exp_chg[n]);
            check_eq($sformatf("%s c%0d accept", tag, n), accept, exp_acc[n]);
            check_eq($sformatf("%s c%0d change_level", tag, n), change_level,
                     n >= cl_on && n < cl_off);
            check_eq($sformatf("%s c%0d accept_level", tag, n), accept_level,
                     n >= al_on && n < al_off);
            btn_change_raw = (n >= c_on && n < c_off);
            btn_accept_raw = (n >= a_on && n < a_off);
            rst_n = !(n >= r_lo && n < r_hi);
        end
        btn_change_raw = 1'b0;
        btn_accept_raw = 1'b0;
        rst_n = 1'b1;
    endtask

    logic [127:0] m_chg;
    logic [127:0] m_acc;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        btn_change_raw = 1'b1;
        btn_accept_raw = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("reset c%0d change", i), change, 1'b0);
            check_eq($sformatf("reset c%0d accept", i), accept, 1'b0);
            check_eq($sformatf("reset c%0d change_level", i), change_level, 1'b0);
            check_eq($sformatf("reset c%0d accept_level", i), accept_level, 1'b0);
        end
        do_reset();

        // Change held 30 cycles.
        m_chg = '0;
        m_chg[6] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        m_chg[26] = 1'b1;
        m_chg[34] = 1'b1;
`endif
        m_acc = '0;
        run_scn("hold30", 45, 0, 30, -1, -1, -1, -1, m_chg, m_acc, 6, 36, -1, -1);
        do_reset();

        // Short accept glitch is filtered.
        m_chg = '0;
        m_acc = '0;
        run_scn("glitch", 15, -1, -1, 0, 3, -1, -1, m_chg, m_acc, -1, -1, -1, -1);
        do_reset();

        // Simultaneous press: accept wins, change level still follows.
        m_chg = '0;
        m_acc = '0;
        m_acc[6] = 1'b1;
        run_scn("both", 25, 0, 12, 0, 12, -1, -1, m_chg, m_acc, 6, 18, 6, 18);
        do_reset();

        // Long hold 0-47.
        m_chg = '0;
        m_chg[6] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        m_chg[26] = 1'b1;
        m_chg[34] = 1'b1;
        m_chg[42] = 1'b1;
        m_chg[50] = 1'b1;
`endif
        m_acc = '0;
        run_scn("hold48", 65, 0, 48, -1, -1, -1, -1, m_chg, m_acc, 6, 54, -1, -1);
        do_reset();

        // Reset low for cycles 5-9 while change held; with repeat on, the
        // delay expiry coincides with the level falling and is suppressed.
        m_chg = '0;
        m_chg[16] = 1'b1;
        m_acc = '0;
        run_scn("midrst", 45, 0, 30, -1, -1, 5, 10, m_chg, m_acc, 16, 36, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
